// File: rtl/mips_exc_pkg.sv
// Shared CP0 exception definitions: FSM state encoding, ExcCode values, default handler vector.
package mips_exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } exc_state_t;

  localparam logic [4:0] EXC_CODE_INT  = 5'd0;
  localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
  localparam logic [4:0] EXC_CODE_ADES = 5'd5;
  localparam logic [4:0] EXC_CODE_SYS  = 5'd8;
  localparam logic [4:0] EXC_CODE_BP   = 5'd9;
  localparam logic [4:0] EXC_CODE_RI   = 5'd10;
  localparam logic [4:0] EXC_CODE_OV   = 5'd12;

  localparam logic [4:0]  EXC_OV_CODE        = EXC_CODE_OV;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

endpackage

// File: rtl/ovf_sat_counter.sv
// Saturating event counter, instantiated by ovf_exc_ctrl only when OVF_EXC_COUNT_EN is defined.
// One cycle from inc to count; sticks at all-ones.
module ovf_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ovf_exc_ctrl.sv
// Signed-overflow exception controller: kills writeback, captures EPC/cause, flushes, redirects, handles ERET.
// wb_kill and redirect are combinational; exc_req follows a trap by one cycle and holds until flush_ack. Optional OVF_EXC_COUNT_EN adds ovf_count.
module ovf_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = mips_exc_pkg::EXC_VECTOR_DEFAULT,
  parameter logic [4:0]  EXC_OV_CODE = mips_exc_pkg::EXC_OV_CODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_trap_op,
  input  logic        ex_overflow,
  input  logic [31:0] ex_pc,
  input  logic        eret,
  input  logic        flush_ack,
  output logic        wb_kill,
  output logic        exc_req,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic [4:0]  cause_exccode,
  output logic        status_exl
`ifdef OVF_EXC_COUNT_EN
  ,
  output logic [15:0] ovf_count
`endif
);

  import mips_exc_pkg::*;

  exc_state_t state, state_nxt;
  logic       trap;
  logic       capture;
  logic       clr_exl;

  assign trap    = ex_valid & ex_trap_op & ex_overflow;
  assign wb_kill = trap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Only a trap taken from IDLE is architecturally recorded; later ones are just killed.
  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    clr_exl        = 1'b0;
    exc_req        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        if (trap) begin
          state_nxt = REQ;
          capture   = 1'b1;
        end
      end
      REQ: begin
        exc_req = 1'b1;
        if (flush_ack) begin
          redirect_valid = 1'b1;
          redirect_pc    = EXC_VECTOR;
          state_nxt      = HANDLER;
        end
      end
      HANDLER: begin
        if (eret) begin
          state_nxt = RETURN;
          clr_exl   = 1'b1;
        end
      end
      RETURN: begin
        redirect_valid = 1'b1;
        redirect_pc    = epc;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // EXL drops as ERET is accepted so it already reads 0 during the return redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc           <= '0;
      cause_exccode <= '0;
      status_exl    <= 1'b0;
    end else if (capture) begin
      epc           <= ex_pc;
      cause_exccode <= EXC_OV_CODE;
      status_exl    <= 1'b1;
    end else if (clr_exl) begin
      status_exl    <= 1'b0;
    end
  end

`ifdef OVF_EXC_COUNT_EN
  ovf_sat_counter #(
    .W (16)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (trap),
    .count (ovf_count)
  );
`endif

endmodule

// File: tb/tb_ovf_exc_ctrl.sv
// Bench for ovf_exc_ctrl: directed scenarios plus randomized run against a flag-based reference model.
module tb_ovf_exc_ctrl;

  localparam logic [31:0] VEC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_trap_op = 1'b0, ex_overflow = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        eret = 1'b0, flush_ack = 1'b0;
  logic        wb_kill, exc_req, redirect_valid, status_exl;
  logic [31:0] redirect_pc, epc;
  logic [4:0]  cause_exccode;
`ifdef OVF_EXC_COUNT_EN
  logic [15:0] ovf_count;
`endif

  int checks = 0;
  int errors = 0;

  ovf_exc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_trap_op     (ex_trap_op),
    .ex_overflow    (ex_overflow),
    .ex_pc          (ex_pc),
    .eret           (eret),
    .flush_ack      (flush_ack),
    .wb_kill        (wb_kill),
    .exc_req        (exc_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .epc            (epc),
    .cause_exccode  (cause_exccode),
    .status_exl     (status_exl)
`ifdef OVF_EXC_COUNT_EN
    ,
    .ovf_count      (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic t, input logic o, input logic [31:0] pc,
                       input logic e, input logic f);
    @(negedge clk);
    ex_valid = v; ex_trap_op = t; ex_overflow = o; ex_pc = pc; eret = e; flush_ack = f;
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    after_edge();
    after_edge();
    checks++; if (exc_req !== 1'b0) begin errors++; $display("FAIL reset_exc_req: got %b want 0", exc_req); end
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++;
      $display("FAIL reset_redirect: got %b/%h want 0/0", redirect_valid, redirect_pc); end
    checks++; if (epc !== 32'h0 || cause_exccode !== 5'd0 || status_exl !== 1'b0) begin errors++;
      $display("FAIL reset_cp0: got epc %h cause %0d exl %b want 0/0/0", epc, cause_exccode, status_exl); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_overflow_flow;
    drive(1, 1, 1, 32'h0040_0010, 0, 0);
    #1;
    checks++; if (wb_kill !== 1'b1 || exc_req !== 1'b0) begin errors++;
      $display("FAIL trap_same_cycle: got kill %b req %b want 1/0", wb_kill, exc_req); end
    after_edge();
    checks++; if (exc_req !== 1'b1 || epc !== 32'h0040_0010 || cause_exccode !== 5'd12 || status_exl !== 1'b1) begin errors++;
      $display("FAIL trap_capture: got req %b epc %h cause %0d exl %b want 1/00400010/12/1",
               exc_req, epc, cause_exccode, status_exl); end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (redirect_valid !== 1'b0 || exc_req !== 1'b1) begin errors++;
      $display("FAIL req_hold: got rv %b req %b want 0/1", redirect_valid, exc_req); end
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== VEC) begin errors++;
      $display("FAIL flush_redirect: got %b/%h want 1/%h", redirect_valid, redirect_pc, VEC); end
    after_edge();
    checks++; if (exc_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b want 0", exc_req); end
    drive(1, 1, 1, 32'h0040_0020, 0, 0);
    #1;
    checks++; if (wb_kill !== 1'b1) begin errors++; $display("FAIL nested_kill: got %b want 1", wb_kill); end
    after_edge();
    checks++; if (epc !== 32'h0040_0010 || exc_req !== 1'b0 || cause_exccode !== 5'd12) begin errors++;
      $display("FAIL nested_discard: got epc %h req %b cause %0d want 00400010/0/12", epc, exc_req, cause_exccode); end
    drive(0, 0, 0, 0, 1, 0);
    after_edge();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0010 || status_exl !== 1'b0) begin errors++;
      $display("FAIL eret_return: got rv %b pc %h exl %b want 1/00400010/0", redirect_valid, redirect_pc, status_exl); end
    drive(0, 0, 0, 0, 0, 0);
    after_edge();
    checks++; if (redirect_valid !== 1'b0 || exc_req !== 1'b0) begin errors++;
      $display("FAIL back_idle: got rv %b req %b want 0/0", redirect_valid, exc_req); end
  endtask

  task automatic test_no_effect;
    drive(1, 0, 1, 32'h0040_0030, 0, 0);
    #1;
    checks++; if (wb_kill !== 1'b0) begin errors++; $display("FAIL unsigned_kill: got %b want 0", wb_kill); end
    after_edge();
    checks++; if (exc_req !== 1'b0 || epc !== 32'h0040_0010 || status_exl !== 1'b0) begin errors++;
      $display("FAIL unsigned_state: got req %b epc %h exl %b want 0/00400010/0", exc_req, epc, status_exl); end
    drive(0, 0, 0, 0, 1, 0);
    after_edge();
    drive(0, 0, 0, 0, 0, 0);
    after_edge();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL idle_eret: got %b want 0", redirect_valid); end
  endtask

  task automatic test_flush_and_trap;
    drive(1, 1, 1, 32'h0040_0100, 0, 0);
    after_edge();
    drive(1, 1, 1, 32'h0040_0200, 0, 1);
    #1;
    checks++; if (wb_kill !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== VEC) begin errors++;
      $display("FAIL ack_trap_comb: got kill %b rv %b pc %h want 1/1/%h", wb_kill, redirect_valid, redirect_pc, VEC); end
    after_edge();
    checks++; if (epc !== 32'h0040_0100 || exc_req !== 1'b0) begin errors++;
      $display("FAIL ack_trap_epc: got epc %h req %b want 00400100/0", epc, exc_req); end
    drive(1, 1, 1, 32'h0040_0300, 1, 0);
    #1;
    checks++; if (wb_kill !== 1'b1) begin errors++; $display("FAIL eret_trap_kill: got %b want 1", wb_kill); end
    after_edge();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0100 || status_exl !== 1'b0 || exc_req !== 1'b0) begin errors++;
      $display("FAIL eret_wins: got rv %b pc %h exl %b req %b want 1/00400100/0/0",
               redirect_valid, redirect_pc, status_exl, exc_req); end
    drive(0, 0, 0, 0, 0, 0);
    after_edge();
  endtask

  task automatic test_back_to_back_and_reset;
    drive(1, 1, 1, 32'h0040_0400, 0, 0);
    after_edge();
    checks++; if (exc_req !== 1'b1 || epc !== 32'h0040_0400) begin errors++;
      $display("FAIL b2b_trap: got req %b epc %h want 1/00400400", exc_req, epc); end
    #1;
    rst = 1'b1;
    #1;
    flush_ack = 1'b1;
    ex_valid = 1'b0;
    #1;
    checks++; if (exc_req !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0 ||
                  epc !== 32'h0 || cause_exccode !== 5'd0 || status_exl !== 1'b0) begin errors++;
      $display("FAIL rst_mid_req: got req %b rv %b pc %h epc %h cause %0d exl %b want all 0",
               exc_req, redirect_valid, redirect_pc, epc, cause_exccode, status_exl); end
    @(negedge clk);
    rst = 1'b0;
    after_edge();
    checks++; if (redirect_valid !== 1'b0 || exc_req !== 1'b0) begin errors++;
      $display("FAIL rst_abandon: got rv %b req %b want 0/0", redirect_valid, exc_req); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  // Reference: one pending-flush flag, one returning flag, and EXL distinguish the phases.
  task automatic test_random;
    logic        m_wait, m_ret, m_exl, trp, r, exp_rv;
    logic [31:0] m_epc, exp_pc;
    logic [4:0]  m_cause;
    int          m_cnt;
    rst = 1'b1;
    after_edge();
    @(negedge clk);
    rst = 1'b0;
    m_wait = 0; m_ret = 0; m_exl = 0; m_epc = '0; m_cause = '0; m_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_trap_op  = $urandom_range(0, 1) == 1;
      ex_overflow = $urandom_range(0, 1) == 1;
      ex_pc       = $urandom & 32'hFFFF_FFFC;
      eret        = ($urandom_range(0, 3) == 0);
      flush_ack   = ($urandom_range(0, 2) == 0);
      r           = ($urandom_range(0, 149) == 0);
      rst         = r;
      #1;
      if (r) begin
        m_wait = 0; m_ret = 0; m_exl = 0; m_epc = '0; m_cause = '0; m_cnt = 0;
      end
      trp    = ex_valid & ex_trap_op & ex_overflow;
      exp_rv = (m_wait & flush_ack) | m_ret;
      exp_pc = (m_wait & flush_ack) ? VEC : (m_ret ? m_epc : 32'h0);
      checks++;
      if (wb_kill !== trp || exc_req !== m_wait || redirect_valid !== exp_rv || redirect_pc !== exp_pc ||
          epc !== m_epc || cause_exccode !== m_cause || status_exl !== m_exl) begin
        errors++;
        $display("FAIL random[%0d]: got kill %b req %b rv %b pc %h epc %h cause %0d exl %b want %b %b %b %h %h %0d %b",
                 i, wb_kill, exc_req, redirect_valid, redirect_pc, epc, cause_exccode, status_exl,
                 trp, m_wait, exp_rv, exp_pc, m_epc, m_cause, m_exl);
      end
`ifdef OVF_EXC_COUNT_EN
      checks++;
      if (ovf_count !== m_cnt[15:0]) begin
        errors++;
        $display("FAIL random_count[%0d]: got %0d want %0d", i, ovf_count, m_cnt);
      end
`endif
      @(posedge clk);
      if (!r) begin
        if (trp && m_cnt < 16'hFFFF) m_cnt++;
        if (m_ret) begin
          m_ret = 0;
        end else if (m_wait) begin
          if (flush_ack) m_wait = 0;
        end else if (m_exl) begin
          if (eret) begin m_ret = 1; m_exl = 0; end
        end else if (trp) begin
          m_epc = ex_pc; m_cause = 5'd12; m_exl = 1; m_wait = 1;
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overflow_flow();
    test_no_effect();
    test_flush_and_trap();
    test_back_to_back_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
